// File: rtl/se_scale_ctrl_pkg.sv
// Shared widths and FSM encoding for the SE channel-scaling controller.
package se_scale_ctrl_pkg;

    localparam int SE_BITSIZE = 14;
    localparam int FRAC_BITS  = 9;
    localparam int SE_ADDR_W  = 13;
    localparam int SE_CH_W    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } se_state_t;

endpackage

// File: rtl/se_addr_gen.sv
// Pixel / channel / linear element counters for one scaling pass.
module se_addr_gen
    import se_scale_ctrl_pkg::*;
#(
    parameter int CH_W   = SE_CH_W,
    parameter int ADDR_W = SE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [CH_W-1:0]   num_ch,
    input  logic [ADDR_W-1:0] num_pix,
    output logic [CH_W-1:0]   ch_idx,
    output logic [ADDR_W-1:0] lin_addr,
    output logic              last
);

    logic [ADDR_W-1:0] pix_idx;
    logic              last_pix;
    logic              last_ch;

    assign last_pix = (pix_idx == num_pix - ADDR_W'(1));
    assign last_ch  = (ch_idx == num_ch - CH_W'(1));
    assign last     = last_pix && last_ch;

    // The linear address runs straight through the pass; only the pixel count wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_idx  <= '0;
            ch_idx   <= '0;
            lin_addr <= '0;
        end else if (clear) begin
            pix_idx  <= '0;
            ch_idx   <= '0;
            lin_addr <= '0;
        end else if (advance) begin
            lin_addr <= lin_addr + ADDR_W'(1);
            if (last_pix) begin
                pix_idx <= '0;
                ch_idx  <= ch_idx + CH_W'(1);
            end else begin
                pix_idx <= pix_idx + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/se_scale_ctrl.sv
// Streams a feature map through an external SE multiplier, scaling each
// element by its channel's scale value and writing the result back.
module se_scale_ctrl
    import se_scale_ctrl_pkg::*;
#(
    parameter int bitsize = SE_BITSIZE,
    parameter int CH_W    = SE_CH_W,
    parameter int ADDR_W  = SE_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CH_W-1:0]    num_ch,
    input  logic [ADDR_W-1:0]  num_pix,
    input  logic               pause,
    output logic               fm_rd_en,
    output logic [ADDR_W-1:0]  fm_rd_addr,
    input  logic [bitsize-1:0] fm_rd_data,
    output logic               sc_rd_en,
    output logic [CH_W-1:0]    sc_rd_addr,
    input  logic [bitsize-1:0] sc_rd_data,
    output logic               mul_start,
    output logic [bitsize-1:0] mul_a,
    output logic [bitsize-1:0] mul_b,
    output logic [ADDR_W-1:0]  mul_addr,
    input  logic               mul_valid,
    input  logic [bitsize-1:0] mul_result,
    input  logic [ADDR_W-1:0]  mul_out_addr,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [bitsize-1:0] wr_data,
    output logic               busy,
    output logic               done
);

    se_state_t         state;
    logic [CH_W-1:0]   cfg_ch;
    logic [ADDR_W-1:0] cfg_pix;
    logic [1:0]        outstanding;
    logic              clear;
    logic              last;
    logic              active;
    logic              accept;
    logic [CH_W-1:0]   ch_idx;
    logic [ADDR_W-1:0] lin_addr;

    assign clear      = (state == IDLE) && start;
    assign active     = (state == ISSUE) || (state == DRAIN);
    assign fm_rd_en   = (state == ISSUE) && !pause;
    assign sc_rd_en   = fm_rd_en;
    assign fm_rd_addr = lin_addr;
    assign sc_rd_addr = ch_idx;

    // Returns outside a pass are leftovers from an aborted run and are dropped.
    assign accept = mul_valid && active;

    // Read data lands one cycle after the read, i.e. together with mul_start.
    assign mul_a = mul_start ? fm_rd_data : '0;
    assign mul_b = mul_start ? sc_rd_data : '0;

    se_addr_gen #(
        .CH_W   (CH_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .advance  (fm_rd_en),
        .num_ch   (cfg_ch),
        .num_pix  (cfg_pix),
        .ch_idx   (ch_idx),
        .lin_addr (lin_addr),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cfg_ch  <= '0;
            cfg_pix <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cfg_ch  <= num_ch;
                        cfg_pix <= num_pix;
                        if ((num_ch == '0) || (num_pix == '0)) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (fm_rd_en && last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == 2'd0) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // At most three elements sit between read and multiplier return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= 2'd0;
        end else begin
            case ({fm_rd_en, accept})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_start <= 1'b0;
            mul_addr  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            mul_start <= fm_rd_en;
            mul_addr  <= fm_rd_addr;
            wr_en     <= accept;
            if (accept) begin
                wr_addr <= mul_out_addr;
                wr_data <= mul_result;
            end
        end
    end

endmodule

// File: tb/tb_se_scale_ctrl.sv
// Directed table-driven bench for se_scale_ctrl with a 2-cycle multiplier model.
module tb_se_scale_ctrl;
    import se_scale_ctrl_pkg::*;

    localparam int BW = 14;
    localparam int CW = 10;
    localparam int AW = 13;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          start   = 1'b0;
    logic          pause   = 1'b0;
    logic [CW-1:0] num_ch  = '0;
    logic [AW-1:0] num_pix = '0;
    logic          fm_rd_en;
    logic [AW-1:0] fm_rd_addr;
    logic [BW-1:0] fm_rd_data = '0;
    logic          sc_rd_en;
    logic [CW-1:0] sc_rd_addr;
    logic [BW-1:0] sc_rd_data = '0;
    logic          mul_start;
    logic [BW-1:0] mul_a;
    logic [BW-1:0] mul_b;
    logic [AW-1:0] mul_addr;
    logic          mul_valid    = 1'b0;
    logic [BW-1:0] mul_result   = '0;
    logic [AW-1:0] mul_out_addr = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          any_out;

    se_scale_ctrl #(.bitsize(BW), .CH_W(CW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_ch(num_ch), .num_pix(num_pix),
        .pause(pause), .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr),
        .fm_rd_data(fm_rd_data), .sc_rd_en(sc_rd_en), .sc_rd_addr(sc_rd_addr),
        .sc_rd_data(sc_rd_data), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_addr(mul_addr), .mul_valid(mul_valid), .mul_result(mul_result),
        .mul_out_addr(mul_out_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    assign any_out = |{fm_rd_en, fm_rd_addr, sc_rd_en, sc_rd_addr, mul_start, mul_a, mul_b,
                       mul_addr, wr_en, wr_addr, wr_data, busy, done};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Feature map and scale memories with one-cycle read latency.
    logic [BW-1:0] fm_mem [0:63];
    logic [BW-1:0] sc_mem [0:3];
    always @(posedge clk) begin
        if (fm_rd_en) fm_rd_data <= fm_mem[fm_rd_addr[5:0]];
        if (sc_rd_en) sc_rd_data <= sc_mem[sc_rd_addr[1:0]];
    end

    function automatic logic [BW-1:0] mul_model(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic signed [2*BW-1:0] prod;
        prod = $signed(a) * $signed(b);
        return prod[FRAC_BITS +: BW];
    endfunction

    // Two-stage multiplier, deliberately not reset so aborted work still returns.
    logic          v1 = 1'b0;
    logic [BW-1:0] p1 = '0;
    logic [AW-1:0] a1 = '0;
    always @(posedge clk) begin
        v1           <= mul_start;
        p1           <= mul_model(mul_a, mul_b);
        a1           <= mul_addr;
        mul_valid    <= v1;
        mul_result   <= p1;
        mul_out_addr <= a1;
    end

    logic          logging = 1'b0;
    int            rd_cnt  = 0;
    int            ms_cnt  = 0;
    logic [AW-1:0] wa_q[$];
    logic [BW-1:0] wd_q[$];
    int            wc_q[$];
    int            dc_q[$];

    always @(negedge clk) begin
        if (logging) begin
            if (fm_rd_en) rd_cnt++;
            if (mul_start) ms_cnt++;
            if (wr_en) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
                wc_q.push_back(cyc);
            end
            if (done) dc_q.push_back(cyc);
        end
    end

    typedef struct {
        int            num_ch;
        int            num_pix;
        int            ps;
        int            pl;
        int            retrig;
        logic [BW-1:0] sc0;
        logic [BW-1:0] sc1;
        logic [BW-1:0] sc2;
        logic [BW-1:0] exp0;
        logic [BW-1:0] exp1;
        logic [BW-1:0] exp2;
        int            exp_n;
        int            exp_first;
        int            exp_done;
    } vec_t;

    vec_t vecs[6];
    int   checks    = 0;
    int   errors    = 0;
    int   start_cyc = 0;

    task automatic check_value(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        dc_q.delete();
        rd_cnt = 0;
        ms_cnt = 0;
    endtask

    task automatic apply_stimulus(input int i);
        vec_t v;
        bit   seen;
        v         = vecs[i];
        sc_mem[0] = v.sc0;
        sc_mem[1] = v.sc1;
        sc_mem[2] = v.sc2;
        clear_log();
        logging = 1'b1;
        @(posedge clk); #1;
        num_ch    = CW'(v.num_ch);
        num_pix   = AW'(v.num_pix);
        start     = 1'b1;
        start_cyc = cyc;
        seen      = 1'b0;
        for (int k = 1; k <= 300 && !seen; k++) begin
            @(posedge clk); #1;
            start = (v.retrig != 0) && (k == 2);
            if ((v.retrig != 0) && (k == 2)) begin
                num_ch  = 10'd3;
                num_pix = 13'd7;
            end
            pause = (k >= v.ps) && (k < v.ps + v.pl);
            if (dc_q.size() > 0) seen = 1'b1;
        end
        start = 1'b0;
        pause = 1'b0;
        if (!seen) begin
            errors++;
            checks++;
            $display("[TB] FAIL v%0d done_timeout got 0 want 1", i);
        end
        repeat (6) @(posedge clk);
        #1;
        logging = 1'b0;
    endtask

    task automatic check_output(input int i);
        vec_t          v;
        int            bad_a;
        int            bad_d;
        int            ch;
        logic [BW-1:0] e;
        v     = vecs[i];
        bad_a = 0;
        bad_d = 0;
        check_value($sformatf("v%0d writes", i), wa_q.size(), v.exp_n);
        check_value($sformatf("v%0d reads", i), rd_cnt, v.exp_n);
        check_value($sformatf("v%0d mul_starts", i), ms_cnt, v.exp_n);
        check_value($sformatf("v%0d done_count", i), dc_q.size(), 1);
        if (dc_q.size() > 0)
            check_value($sformatf("v%0d done_latency", i), dc_q[0] - start_cyc, v.exp_done);
        if (v.exp_n > 0 && wa_q.size() > 0) begin
            check_value($sformatf("v%0d first_write_latency", i), wc_q[0] - start_cyc, v.exp_first);
            if (dc_q.size() > 0)
                check_value($sformatf("v%0d done_after_last_write", i), dc_q[0] - wc_q[$], 1);
            if (v.pl == 0)
                check_value($sformatf("v%0d write_span", i), wc_q[$] - wc_q[0], v.exp_n - 1);
            else
                check_value($sformatf("v%0d write_gap", i), int'(wc_q[$] - wc_q[0] > v.exp_n - 1), 1);
            for (int j = 0; j < wa_q.size(); j++) begin
                if (int'(wa_q[j]) != j) bad_a++;
                ch = j / v.num_pix;
                e  = (ch == 0) ? v.exp0 : (ch == 1) ? v.exp1 : v.exp2;
                if (wd_q[j] !== e) bad_d++;
            end
            check_value($sformatf("v%0d bad_addresses", i), bad_a, 0);
            check_value($sformatf("v%0d bad_data", i), bad_d, 0);
        end
    endtask

    initial begin
        for (int a = 0; a < 64; a++) fm_mem[a] = 14'h200;
        for (int a = 0; a < 4; a++) sc_mem[a] = 14'h0;

        vecs[0] = '{2, 3, 0, 0, 1, 14'h100, 14'h400, 14'h0,
                    14'h100, 14'h400, 14'h0, 6, 5, 11};
        vecs[1] = '{1, 4, 0, 0, 0, 14'h200, 14'h0, 14'h0,
                    14'h200, 14'h0, 14'h0, 4, 5, 9};
        vecs[2] = '{2, 5, 3, 3, 0, 14'h080, 14'h600, 14'h0,
                    14'h080, 14'h600, 14'h0, 10, 5, 18};
        vecs[3] = '{3, 1, 0, 0, 0, 14'h200, 14'h100, 14'h3E00,
                    14'h200, 14'h100, 14'h3E00, 3, 5, 8};
        vecs[4] = '{3, 0, 0, 0, 0, 14'h200, 14'h0, 14'h0,
                    14'h0, 14'h0, 14'h0, 0, 0, 1};
        vecs[5] = '{0, 4, 0, 0, 0, 14'h200, 14'h0, 14'h0,
                    14'h0, 14'h0, 14'h0, 0, 0, 1};

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_outputs_nonzero", int'(any_out), 0);
        check_value("reset_busy", int'(busy), 0);
        check_value("reset_done", int'(done), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(i);
            check_output(i);
        end

        // Abort a pass mid-ISSUE while results are still in the multiplier.
        sc_mem[0] = 14'h080;
        sc_mem[1] = 14'h600;
        @(posedge clk); #1;
        num_ch  = 10'd2;
        num_pix = 13'd5;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("busy_before_abort", int'(busy), 1);
        rst = 1'b0;
        #1;
        check_value("abort_outputs_nonzero", int'(any_out), 0);
        clear_log();
        logging = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        logging = 1'b0;
        check_value("abort_stray_writes", wa_q.size(), 0);
        check_value("abort_stray_done", dc_q.size(), 0);
        check_value("abort_stray_reads", rd_cnt, 0);
        check_value("abort_busy", int'(busy), 0);

        apply_stimulus(0);
        check_output(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/se_scale_ctrl.md
SE_SCALE_CTRL -- requirements
Module: se_scale_ctrl

Interface
REQ-001 Parameter bitsize, default 14: fixed-point operand width; 9 fractional bits, matching the SE multiplier.
REQ-002 Parameter CH_W, default 10: channel count/index width.
REQ-003 Parameter ADDR_W, default 13: feature-map address width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse; latches config and begins a pass.
REQ-007 num_ch  in  CH_W  channel count (1..1023).
REQ-008 num_pix  in  ADDR_W  pixels per channel; num_ch*num_pix <= 2^ADDR_W.
REQ-009 pause  in  1  when high, no new element is issued.
REQ-010 fm_rd_en / fm_rd_addr  out  1 / ADDR_W  feature-map read; data returns next cycle.
REQ-011 fm_rd_data  in  bitsize  feature-map read data.
REQ-012 sc_rd_en / sc_rd_addr  out  1 / CH_W  SE scale-vector read; data returns next cycle.
REQ-013 sc_rd_data  in  bitsize  scale value for the channel.
REQ-014 mul_start / mul_a / mul_b / mul_addr  out  1 / bitsize / bitsize / ADDR_W  multiplier issue port.
REQ-015 mul_valid / mul_result / mul_out_addr  in  1 / bitsize / ADDR_W  multiplier return, 2 cycles after mul_start.
REQ-016 wr_en / wr_addr / wr_data  out  1 / ADDR_W / bitsize  registered write of the scaled element.
REQ-017 busy / done  out  1 / 1  pass in progress / one-cycle completion pulse.

Function
REQ-018 FSM states: IDLE, ISSUE, DRAIN, FIN; IDLE->ISSUE on start with valid config; ISSUE->DRAIN after the last element is issued; DRAIN->FIN when outstanding==0; FIN->IDLE unconditionally.
REQ-019 start with num_ch==0 or num_pix==0 goes IDLE->FIN: done pulses without any read or issue.
REQ-020 start while busy is ignored; config is sampled only in IDLE.
REQ-021 In ISSUE with pause low: one element per cycle, fm_rd_addr = linear counter 0..total-1, sc_rd_addr = channel index.
REQ-022 Pixel counter wraps at num_pix-1 to 0 and increments the channel index; the linear address never wraps within a pass.
REQ-023 mul_start is fm_rd_en delayed 1 cycle; mul_a=fm_rd_data, mul_b=sc_rd_data, mul_addr = read address delayed 1 cycle.
REQ-024 pause high stops new reads that cycle; reads already issued still produce mul_start; no element is skipped or duplicated.
REQ-025 Outstanding counter (0..3): +1 on fm_rd_en, -1 on mul_valid, net 0 when both occur in the same cycle.
REQ-026 wr_en/wr_addr/wr_data = mul_valid/mul_out_addr/mul_result registered 1 cycle.
REQ-027 Element issued at read cycle t: mul_start at t+1, mul_valid at t+3, wr_en at t+4.
REQ-028 done pulses for 1 cycle in FIN, after the final wr_en; busy is high in ISSUE and DRAIN.
REQ-029 Multiplier saturation/rounding is not altered; results pass through unmodified.

Reset
REQ-030 On rst low: FSM->IDLE; all counters 0; every output, including busy and done, is 0.
REQ-031 rst asserted mid-pass aborts immediately; in-flight results are discarded, with no wr_en after reset release.

Structure
REQ-032 A shared package holds bitsize, FRAC_BITS=9, ADDR_W, CH_W and the FSM state encoding.
REQ-033 The SE multiplier is instantiated externally; the only natural sub-module is se_addr_gen, containing the pixel/channel/linear counters.

Verification
REQ-034 num_ch=2, num_pix=3, fm=1.0 (0x200), scales 0.5/2.0 -> 6 writes at addr 0..5; data 0x100 x3, then 0x400 x3; done 1 cycle after the last write.
REQ-035 num_ch=1, num_pix=4, continuous issue -> first wr_en exactly 5 cycles after start (read at start+1, write at read+4); 4 consecutive write cycles.
REQ-036 pause high for 3 cycles mid-pass -> write sequence has a gap but addresses stay contiguous with no duplicates; total writes = num_ch*num_pix.
REQ-037 num_pix=0 -> done after 1 FSM transition; fm_rd_en, mul_start and wr_en never assert.
REQ-038 start pulsed again while busy -> ignored, single done; rst low during ISSUE -> all outputs 0 and no later wr_en.
